// File: rtl/bus_reg_bank_if.sv
// Request/response bus between a master and the bus_reg_bank register bank.
interface bus_reg_bank_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) ();
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr, addr, wdata, input ack, err, rdata);
  modport slave  (input req, wr, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/bus_reg_bank.sv
// Parametrised register bank with req/ack/err bus and start pulse from CONT_REG bit 0.
// Define BUS_REG_BANK_ERR_CNT_EN to map a saturating miss counter at BASE_ADDR+NUM_REGS.
module bus_reg_bank #(
  parameter int              DATA_W    = 64,
  parameter int              ADDR_W    = 16,
  parameter int              NUM_REGS  = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0120
) (
  input  logic                       clk,
  input  logic                       reset,
  bus_reg_bank_if.slave              bus,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic                       start
);

`ifdef BUS_REG_BANK_ERR_CNT_EN
  localparam int CNT_SLOTS = 1;
`else
  localparam int CNT_SLOTS = 0;
`endif
  localparam longint unsigned WIN_END  = 64'(BASE_ADDR) + 64'(NUM_REGS + CNT_SLOTS) - 64'd1;
  localparam longint unsigned ADDR_MAX = (64'd1 << ADDR_W) - 64'd1;
  localparam int              IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  if (WIN_END > ADDR_MAX) begin : g_window_check
    $error("bus_reg_bank: register window extends past the top of the address space");
  end
  if (NUM_REGS < 2 || NUM_REGS > 64 || DATA_W < 8) begin : g_param_check
    $error("bus_reg_bank: NUM_REGS must be 2..64 and DATA_W at least 8");
  end

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_sel;
  logic              w_hit;
  logic              w_cnt_hit;
  logic              w_accept;
  logic [DATA_W-1:0] w_cnt_ext;

  // Offset is taken at bus width, so addresses below the base never alias into the window.
  assign w_off    = bus.addr - BASE_ADDR;
  assign w_hit    = (bus.addr >= BASE_ADDR) && (w_off < ADDR_W'(NUM_REGS));
  assign w_sel    = w_off[IDX_W-1:0];
  assign w_accept = (r_state == S_IDLE) && bus.req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.req) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.ack   = (r_state == S_RESP);
  assign bus.err   = bus.ack & r_err;
  assign bus.rdata = r_rdata;
  assign start     = r_regs[0][0];

  // Start bit clears on the edge after it was set; a write on that same edge still wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (r_regs[0][0]) r_regs[0][0] <= 1'b0;
      if (w_accept && bus.wr && w_hit) r_regs[w_sel] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_err <= !(w_hit || w_cnt_hit);
      if (!w_hit && !w_cnt_hit) r_rdata <= '0;
      else if (!bus.wr)         r_rdata <= w_hit ? r_regs[w_sel] : w_cnt_ext;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = r_regs[g];
  end

`ifdef BUS_REG_BANK_ERR_CNT_EN
  localparam int CNT_W = (DATA_W < 16) ? DATA_W : 16;

  logic [15:0] r_err_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_cnt_hit = (bus.addr >= BASE_ADDR) && (w_off == ADDR_W'(NUM_REGS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_accept) begin
      if (w_cnt_hit && bus.wr)    r_err_cnt <= '0;
      else if (!w_hit && !w_cnt_hit) r_err_cnt <= sat_inc16(r_err_cnt);
    end
  end

  always_comb begin
    w_cnt_ext = '0;
    w_cnt_ext[CNT_W-1:0] = r_err_cnt[CNT_W-1:0];
  end
`else
  assign w_cnt_hit = 1'b0;
  assign w_cnt_ext = '0;
`endif

endmodule

// File: tb/tb_bus_reg_bank.sv
// Self-checking bench for bus_reg_bank: directed steps plus random traffic against a reference model.
module tb_bus_reg_bank;
  localparam int          DW    = 64;
  localparam int          AW    = 16;
  localparam int          NREGS = 3;
  localparam logic [15:0] BASE  = 16'h0120;
`ifdef BUS_REG_BANK_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [NREGS*DW-1:0] reg_out;
  logic             start;

  int total;
  int bad;

  logic [63:0] m [NREGS];
  logic [15:0] cnt;

  bus_reg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_reg_bank #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NREGS), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .reg_out(reg_out), .start(start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] flat();
    return {m[2], m[1], m[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m[i] = '0;
    cnt = '0;
  endtask

  // One complete transaction: accept, one-cycle response, then back in IDLE.
  task automatic xact(input bit w, input logic [15:0] a, input logic [63:0] d,
                      output logic [63:0] rd);
    logic [15:0] off;
    bit          hit, chit, e_start;
    logic [63:0] e_rd;
    off     = a - BASE;
    hit     = (a >= BASE) && (int'(off) < NREGS);
    chit    = CNT_EN && (a >= BASE) && (int'(off) == NREGS);
    e_start = w && hit && (off == 16'd0) && d[0];
    if (hit)       e_rd = m[int'(off)];
    else if (chit) e_rd = 64'(cnt);
    else           e_rd = 64'd0;

    @(negedge clk);
    bus.req   = 1'b1;
    bus.wr    = w;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk); #1;
    bus.req = 1'b0;

    if (w && hit) m[int'(off)] = d;
    if (!hit && !chit)  cnt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    else if (chit && w) cnt = 16'd0;

    check("ack", 192'(bus.ack), 192'(1));
    check("err", 192'(bus.err), 192'(!(hit || chit)));
    if (!w || !(hit || chit)) check("rdata", 192'(bus.rdata), 192'(e_rd));
    check("start", 192'(start), 192'(e_start));
    check("reg_out", reg_out, flat());
    rd = bus.rdata;
    if (e_start) m[0][0] = 1'b0;

    @(posedge clk); #1;
    check("ack_low", 192'(bus.ack), 192'(0));
    check("err_low", 192'(bus.err), 192'(0));
    check("start_low", 192'(start), 192'(0));
    check("reg_out_after", reg_out, flat());
  endtask

  initial begin
    logic [63:0] rd;
    logic [15:0] a;
    logic [63:0] d;
    bit          w;
    logic [15:0] b2b_a [4];
    logic [63:0] b2b_d [4];
    int          acks;

    total = 0;
    bad   = 0;
    bus.req   = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    reset     = 1'b1;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 192'(bus.ack), 192'(0));
    check("rst_err", 192'(bus.err), 192'(0));
    check("rst_rdata", 192'(bus.rdata), 192'(0));
    check("rst_start", 192'(start), 192'(0));
    check("rst_reg_out", reg_out, 192'(0));
    @(negedge clk);
    reset = 1'b0;

    xact(1'b0, 16'h0121, 64'd0, rd);
    check("first_read", 192'(rd), 192'(0));

    xact(1'b1, 16'h0122, 64'hDEAD_BEEF_0123_4567, rd);
    xact(1'b0, 16'h0122, 64'd0, rd);
    check("reg2_read", 192'(rd), 192'(64'hDEAD_BEEF_0123_4567));
    check("reg2_slice", 192'(reg_out[191:128]), 192'(64'hDEAD_BEEF_0123_4567));

    xact(1'b1, 16'h0120, 64'h0000_0000_0000_00F1, rd);
    xact(1'b0, 16'h0120, 64'd0, rd);
    check("cont_readback", 192'(rd), 192'(64'hF0));

    xact(1'b0, 16'h0123, 64'd0, rd);
    xact(1'b1, 16'h011F, 64'h1234_5678_9ABC_DEF0, rd);
    xact(1'b0, 16'h0123, 64'd0, rd);
    xact(1'b1, 16'h0123, 64'hFFFF_FFFF_FFFF_FFFF, rd);
    xact(1'b0, 16'h0123, 64'd0, rd);

    // Back-to-back writes with req held high throughout.
    b2b_a[0] = 16'h0120; b2b_a[1] = 16'h0121; b2b_a[2] = 16'h0122; b2b_a[3] = 16'h011F;
    for (int k = 0; k < 4; k++) b2b_d[k] = {$urandom, $urandom} & ~64'd1;
    acks = 0;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.wr    = 1'b1;
    bus.addr  = b2b_a[0];
    bus.wdata = b2b_d[0];
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.ack) acks++;
      check("b2b_ack", 192'(bus.ack), 192'(i % 2 == 0));
      if (i % 2 == 0) begin
        check("b2b_err", 192'(bus.err), 192'(i == 6));
        if (i < 6) begin
          bus.addr  = b2b_a[i/2 + 1];
          bus.wdata = b2b_d[i/2 + 1];
        end else begin
          bus.req = 1'b0;
        end
      end
    end
    for (int k = 0; k < 3; k++) m[k] = b2b_d[k];
    cnt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    check("b2b_count", 192'(acks), 192'(4));
    check("b2b_regs", reg_out, flat());

    for (int n = 0; n < 60; n++) begin
      a = 16'h011E + 16'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      if (a == BASE && $urandom_range(0, 2) != 0) d[0] = 1'b0;
      xact(w, a, d, rd);
    end

    xact(1'b1, 16'h0121, 64'hA5A5_0000_FFFF_1234, rd);
    @(negedge clk);
    bus.req  = 1'b1;
    bus.wr   = 1'b0;
    bus.addr = 16'h0121;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("abort_pre_ack", 192'(bus.ack), 192'(1));
    reset = 1'b1;
    #1;
    model_reset();
    check("abort_ack", 192'(bus.ack), 192'(0));
    check("abort_err", 192'(bus.err), 192'(0));
    check("abort_rdata", 192'(bus.rdata), 192'(0));
    check("abort_start", 192'(start), 192'(0));
    check("abort_reg_out", reg_out, 192'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_no_ack", 192'(bus.ack), 192'(0));

    xact(1'b0, 16'h0121, 64'd0, rd);
    xact(1'b1, 16'h0121, 64'h0F0F_0F0F_0F0F_0F0F, rd);
    xact(1'b0, 16'h0121, 64'd0, rd);
    check("post_reset_read", 192'(rd), 192'(64'h0F0F_0F0F_0F0F_0F0F));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
